// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 responder: opcode masks, DDRAM layout,
// bus-capture record, control-state record and address helpers.
package lcd_pkg;

    // Shadow geometry: two visible lines of sixteen characters each
    localparam int LINE_LEN     = 16;
    localparam int SHADOW_DEPTH = 32;
    localparam int SHADOW_AW    = 5;

    // DDRAM line bases and the two-line wrap points of the address counter
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] WRAP_LINE1 = 7'h27;
    localparam logic [6:0] WRAP_LINE2 = 7'h67;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Instruction opcode masks and values, decoded from the MSB down
    localparam logic [7:0] MASK_DDRAM = 8'h80, VAL_DDRAM = 8'h80;
    localparam logic [7:0] MASK_CGRAM = 8'hC0, VAL_CGRAM = 8'h40;
    localparam logic [7:0] MASK_FUNC  = 8'hE0, VAL_FUNC  = 8'h20;
    localparam logic [7:0] MASK_SHIFT = 8'hF0, VAL_SHIFT = 8'h10;
    localparam logic [7:0] MASK_DISP  = 8'hF8, VAL_DISP  = 8'h08;
    localparam logic [7:0] MASK_ENTRY = 8'hFC, VAL_ENTRY = 8'h04;
    localparam logic [7:0] MASK_HOME  = 8'hFE, VAL_HOME  = 8'h02;
    localparam logic [7:0] MASK_CLEAR = 8'hFF, VAL_CLEAR = 8'h01;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } lcd_op_e;

    typedef enum logic {
        FILL_IDLE,
        FILL_RUN
    } fill_state_e;

    // One sampled snapshot of the LCD bus
    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_bus_t;

    // Architectural state visible to the writer
    typedef struct packed {
        logic [6:0] ac;
        logic       disp_on;
        logic       cur_on;
        logic       blink_on;
        logic       entry_inc;
        logic       entry_shift;
        logic       func_8bit;
        logic       func_2line;
        logic       initialized;
        logic       cg_mode;
        logic       err_busy;
        logic       err_read;
    } lcd_ctrl_t;

    localparam lcd_ctrl_t CTRL_RESET = '{
        ac:          7'h00,
        disp_on:     1'b0,
        cur_on:      1'b0,
        blink_on:    1'b0,
        entry_inc:   1'b1,
        entry_shift: 1'b0,
        func_8bit:   1'b0,
        func_2line:  1'b0,
        initialized: 1'b0,
        cg_mode:     1'b0,
        err_busy:    1'b0,
        err_read:    1'b0
    };

    // Classify an instruction byte; the first matching mask from the MSB wins
    function automatic lcd_op_e decode_op(input logic [7:0] d);
        lcd_op_e op;
        op = OP_NOP;
        if      ((d & MASK_DDRAM) == VAL_DDRAM) op = OP_DDRAM;
        else if ((d & MASK_CGRAM) == VAL_CGRAM) op = OP_CGRAM;
        else if ((d & MASK_FUNC)  == VAL_FUNC)  op = OP_FUNC;
        else if ((d & MASK_SHIFT) == VAL_SHIFT) op = OP_SHIFT;
        else if ((d & MASK_DISP)  == VAL_DISP)  op = OP_DISPLAY;
        else if ((d & MASK_ENTRY) == VAL_ENTRY) op = OP_ENTRY;
        else if ((d & MASK_HOME)  == VAL_HOME)  op = OP_HOME;
        else if ((d & MASK_CLEAR) == VAL_CLEAR) op = OP_CLEAR;
        return op;
    endfunction

    // Two-line address counter step; out-of-range addresses step plainly mod 128
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if      (ac == WRAP_LINE1) nxt = LINE2_BASE;
            else if (ac == WRAP_LINE2) nxt = LINE1_BASE;
            else                       nxt = ac + 7'd1;
        end else begin
            if      (ac == LINE1_BASE) nxt = WRAP_LINE2;
            else if (ac == LINE2_BASE) nxt = WRAP_LINE1;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // True when the address falls in the first sixteen cells of either line
    function automatic logic ac_visible(input logic [6:0] ac);
        return ((ac & 7'h70) == LINE1_BASE) || ((ac & 7'h70) == LINE2_BASE);
    endfunction

    // Shadow index of a visible address: line select in bit 4, column below
    function automatic logic [SHADOW_AW-1:0] ac_index(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_ddram_buf.sv
// 32x8 shadow of the visible DDRAM cells: one write port, one registered read
// port, and a sequencer that blanks every cell after reset or on request.
module lcd_ddram_buf
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fill_start,
    input  logic                 we,
    input  logic [SHADOW_AW-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [SHADOW_AW-1:0] raddr,
    output logic [7:0]           rdata,
    output logic                 filling
);

    logic [7:0]           mem [SHADOW_DEPTH];
    fill_state_e          state, state_nxt;
    logic [SHADOW_AW-1:0] fill_idx, fill_idx_nxt;

    // Fill sequencer state register; reset starts a fill immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL_RUN;
            fill_idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            fill_idx <= fill_idx_nxt;
        end
    end

    // Fill sequencer next state: walk all 32 cells once, then idle
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        fill_idx_nxt = fill_idx;
        case (state)
            FILL_IDLE: begin
                if (fill_start) begin
                    state_nxt    = FILL_RUN;
                    fill_idx_nxt = '0;
                end
            end
            FILL_RUN: begin
                fill_idx_nxt = fill_idx + 5'd1;
                if (fill_idx == 5'(SHADOW_DEPTH - 1)) state_nxt = FILL_IDLE;
            end
            default: state_nxt = FILL_IDLE;
        endcase
    end

    assign filling = (state == FILL_RUN);

    // Storage write port; the blanking fill has priority over character writes
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term so it maps onto RAM; the fill sequencer blanks it instead.
        if (filling)  mem[fill_idx] <= BLANK_CHAR;
        else if (we)  mem[waddr]    <= wdata;
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else      rdata <= mem[raddr];
    end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible bus responder: captures E-strobed transactions, decodes
// the instruction set, keeps a shadow of the visible text and models busy time.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CMD_CYC = 37,
    parameter int BUSY_CLR_CYC = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       initialized,
    output logic       busy,
    output logic       upd,
    output logic       err_busy,
    output logic       err_read
);

    localparam int CNT_W = $clog2(BUSY_CLR_CYC + 1);

    lcd_bus_t             s1, s2;
    logic                 strobe;
    lcd_op_e              op;
    lcd_ctrl_t            ctrl_q, ctrl_d;
    logic                 upd_d;
    logic [CNT_W-1:0]     busy_cnt, busy_d;
    logic                 buf_we;
    logic [SHADOW_AW-1:0] buf_waddr;
    logic                 fill_start;
    logic                 filling;

    // Two-stage capture of the bus; s2 holds the last E-high sample at the falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= '{e: lcd_e, rs: lcd_rs, rw: lcd_rw, data: lcd_data};
            s2 <= s1;
        end
    end

    assign strobe = s2.e & ~s1.e;
    assign op     = decode_op(s2.data);
    assign busy   = (busy_cnt != '0) | filling;

    // Transaction decode, address stepping and busy-time bookkeeping
    always_comb begin
        ctrl_d     = ctrl_q;
        upd_d      = 1'b0;
        busy_d     = (busy_cnt != '0) ? busy_cnt - CNT_W'(1) : '0;
        buf_we     = 1'b0;
        buf_waddr  = ac_index(ctrl_q.ac);
        fill_start = 1'b0;
        if (strobe) begin
            if (s2.rw) begin
                ctrl_d.err_read = 1'b1;
            end else if (busy) begin
                // Dropped: the running busy count is left untouched
                ctrl_d.err_busy = 1'b1;
            end else if (s2.rs) begin
                busy_d = CNT_W'(BUSY_CMD_CYC);
                // Character-generator data has no shadow, so it is discarded outright
                if (!ctrl_q.cg_mode) begin
                    if (ac_visible(ctrl_q.ac)) begin
                        buf_we = 1'b1;
                        upd_d  = 1'b1;
                    end
                    ctrl_d.ac = ac_step(ctrl_q.ac, ctrl_q.entry_inc);
                end
            end else begin
                busy_d = CNT_W'(BUSY_CMD_CYC);
                case (op)
                    OP_DDRAM: begin
                        ctrl_d.ac      = s2.data[6:0];
                        ctrl_d.cg_mode = 1'b0;
                    end
                    OP_CGRAM: ctrl_d.cg_mode = 1'b1;
                    OP_FUNC: begin
                        ctrl_d.func_8bit  = s2.data[4];
                        ctrl_d.func_2line = s2.data[3];
                        if (s2.data[4]) ctrl_d.initialized = 1'b1;
                    end
                    OP_SHIFT: begin
                        // Display shifts do not change the shadow; only cursor moves act
                        if (!s2.data[3]) ctrl_d.ac = ac_step(ctrl_q.ac, s2.data[2]);
                    end
                    OP_DISPLAY: begin
                        ctrl_d.disp_on  = s2.data[2];
                        ctrl_d.cur_on   = s2.data[1];
                        ctrl_d.blink_on = s2.data[0];
                    end
                    OP_ENTRY: begin
                        ctrl_d.entry_inc   = s2.data[1];
                        ctrl_d.entry_shift = s2.data[0];
                    end
                    OP_HOME: begin
                        busy_d         = CNT_W'(BUSY_CLR_CYC);
                        ctrl_d.ac      = 7'h00;
                        ctrl_d.cg_mode = 1'b0;
                    end
                    OP_CLEAR: begin
                        busy_d           = CNT_W'(BUSY_CLR_CYC);
                        fill_start       = 1'b1;
                        ctrl_d.ac        = 7'h00;
                        ctrl_d.entry_inc = 1'b1;
                        ctrl_d.cg_mode   = 1'b0;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end

    // Control, pulse and busy-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= CTRL_RESET;
            upd      <= 1'b0;
            busy_cnt <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            upd      <= upd_d;
            busy_cnt <= busy_d;
        end
    end

    lcd_ddram_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .we         (buf_we),
        .waddr      (buf_waddr),
        .wdata      (s2.data),
        .raddr      (rd_addr),
        .rdata      (rd_char),
        .filling    (filling)
    );

    assign cursor      = ctrl_q.ac;
    assign disp_on     = ctrl_q.disp_on;
    assign cur_on      = ctrl_q.cur_on;
    assign blink_on    = ctrl_q.blink_on;
    assign entry_inc   = ctrl_q.entry_inc;
    assign entry_shift = ctrl_q.entry_shift;
    assign func_8bit   = ctrl_q.func_8bit;
    assign func_2line  = ctrl_q.func_2line;
    assign initialized = ctrl_q.initialized;
    assign err_busy    = ctrl_q.err_busy;
    assign err_read    = ctrl_q.err_read;

endmodule
